hist_lut_loader: RTL and testbench
==================================

// Module: hist_lut_loader
// PURPOSE
//  Sequences the per-frame equalisation-LUT rebuild for the ping-pong LUT regenerator.
//  - On a frame-done pulse, reads the 256-bin histogram RAM and accumulates the CDF.
//  - Scales each CDF value to 0..255.
//  - Streams 256 writes (update/update_address/update_data) into the LUT bank idle this frame.
//  - Sits between the histogram-statistics RAM and the regenerator's update port.
// PARAMETERS
//  BIN_W    20     width of a histogram bin / CDF accumulator
//  SCALE_W  16     width of SCALE
//  SCALE    13926  round(255 * 2^SHIFT / total_pixels); default for 640x480
//  SHIFT    24     right shift applied to cdf*SCALE
// PORTS
//  clk             in   1      clock
//  rst             in   1      asynchronous reset, active-high
//  start           in   1      1-cycle pulse: histogram for the frame is complete
//  hist_rden       out  1      histogram RAM read enable
//  hist_rdaddr     out  8      histogram RAM read address
//  hist_q          in   BIN_W  histogram RAM data; valid 1 cycle after hist_rden
//  hist_wren       out  1      histogram RAM write enable (HIST_CLEAR_EN only; else tied 0)
//  hist_wraddr     out  8      histogram RAM write address (HIST_CLEAR_EN only; else tied 0)
//  update          out  1      LUT write strobe
//  update_address  out  8      LUT write address
//  update_data     out  8      LUT write data
//  busy            out  1      high from start acceptance until done
//  done            out  1      1-cycle pulse after the last LUT write
//  overrun         out  1      1-cycle pulse: start arrived while busy
// BEHAVIOUR
//  - Reset values:
//    - All outputs 0.
//    - state=IDLE; cdf, rd counter and pipeline valids cleared.
//  - FSM IDLE -> READ -> DRAIN -> FIN -> IDLE.
//    - IDLE: start=1 at edge T -> READ; busy=1 from T+1; cdf<=0.
//    - READ: cycles T+1..T+256 assert hist_rden with hist_rdaddr=0..255, one per cycle.
//      After address 255 -> DRAIN.
//    - DRAIN: waits for the pipeline to empty (3 cycles), then -> FIN.
//    - FIN: done=1 for one cycle, busy drops the same edge -> IDLE.
//  - Pipeline per address a issued at cycle C:
//    - C+1: hist_q valid; cdf <= sat(cdf + hist_q), saturating at 2^BIN_W-1.
//    - C+2: prod <= cdf*SCALE + 2^(SHIFT-1); width BIN_W+SCALE_W, unsigned.
//    - C+3: update=1, update_address=a, update_data = min(prod>>SHIFT, 255).
//  - Writes are contiguous: 256 consecutive update cycles, T+4..T+259.
//  - done at T+260. Start-to-done = 260 cycles.
//  - start while busy: ignored, overrun=1 that cycle; the sequence in flight is not disturbed.
//  - start in the same cycle as done: accepted (FIN -> READ directly).
//  - Reset mid-sequence: immediate return to IDLE.
//    - The LUT bank is left partially written; no done pulse.
//  - Bank selection is owned by the regenerator's eop toggle; this block never sees it.
//    The system guarantees 260 cycles between start and the next sink_eop.
// CONFIGURATION
//  - `define HIST_CLEAR_EN set:
//    - Each bin read is cleared for the next frame.
//    - hist_wren=1, hist_wraddr=a at C+1 (write data 0 is driven by the RAM wrapper).
//  - `define HIST_CLEAR_EN not set:
//    - hist_wren and hist_wraddr tied 0; the histogram RAM is untouched.
// STRUCTURE
//  - Package hist_eq_pkg:
//    - NBINS=256, LUT_MAX=8'd255.
//    - State encoding localparams S_IDLE/S_READ/S_DRAIN/S_FIN.
//    - Pipeline depth constant PIPE_LAT=3.
//  - Sub-module hist_lut_scale holds the multiply/round/shift/clamp stages (C+2, C+3).
//    It carries the address and valid alongside the data.
//  - The top holds the FSM, the read counter and the CDF accumulator.
// TESTING
//  1. Uniform hist, every bin 1200:
//     start -> 256 updates.
//     LUT[0]=1, LUT[127]=127, LUT[255]=255; done at T+260.
//  2. hist[0]=307200, all other bins 0:
//     -> every update_data=255; update_address sequence 0..255 with no gaps.
//  3. All bins 0:
//     -> every update_data=0; busy high exactly 259 cycles.
//  4. start pulsed at T+100 during a sequence:
//     -> overrun=1 at T+100; output stream identical to test 1; single done.
//  5. rst asserted at T+50, released at T+52:
//     -> update=busy=0 immediately; next start gives a full, correct 256-write sequence.
//  6. With HIST_CLEAR_EN, run test 1, then start again:
//     -> hist_wren for addresses 0..255; second pass outputs LUT all 0.

Source files
------------

// File: rtl/hist_eq_pkg.sv
// Shared constants for the histogram-equalisation LUT loader: bin count, LUT ceiling,
// FSM state encoding and the depth of the read/accumulate/scale pipeline.
package hist_eq_pkg;
  localparam int         NBINS    = 256;
  localparam logic [7:0] LUT_MAX  = 8'd255;
  localparam int         PIPE_LAT = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;
endpackage

// File: rtl/hist_lut_scale.sv
// Scale stage: prod = cdf*SCALE + half-LSB, registered, then shifted and clamped to 0..255.
// Address and valid travel with the data so the output is a self-contained write strobe.
module hist_lut_scale
  import hist_eq_pkg::*;
#(
  parameter int BIN_W   = 20,
  parameter int SCALE_W = 16,
  parameter int SCALE   = 13926,
  parameter int SHIFT   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_addr,
  input  logic [BIN_W-1:0] in_cdf,
  output logic             out_valid,
  output logic [7:0]       out_addr,
  output logic [7:0]       out_data
);
  localparam int PROD_W = BIN_W + SCALE_W;
  localparam logic [PROD_W-1:0]  ROUND_ONE = 1;
  localparam logic [PROD_W-1:0]  ROUND     = ROUND_ONE << (SHIFT - 1);
  localparam logic [SCALE_W-1:0] SCALE_C   = SCALE_W'(SCALE);

  logic              valid_q, valid_d;
  logic [7:0]        addr_q, addr_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [PROD_W-1:0] shifted;

  always_comb begin
    valid_d = in_valid;
    addr_d  = in_valid ? in_addr : addr_q;
    prod_d  = prod_q;
    if (in_valid)
      prod_d = {{SCALE_W{1'b0}}, in_cdf} * {{BIN_W{1'b0}}, SCALE_C} + ROUND;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      prod_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    shifted   = prod_q >> SHIFT;
    out_valid = valid_q;
    out_addr  = valid_q ? addr_q : 8'd0;
    out_data  = 8'd0;
    if (valid_q)
      out_data = (shifted > PROD_W'(LUT_MAX)) ? LUT_MAX : shifted[7:0];
  end
endmodule

// File: rtl/hist_lut_loader.sv
// Per-frame LUT rebuild: reads 256 histogram bins, accumulates a saturating CDF and
// streams scaled LUT writes. `define HIST_CLEAR_EN clears each bin as it is read.
module hist_lut_loader
  import hist_eq_pkg::*;
#(
  parameter int BIN_W   = 20,
  parameter int SCALE_W = 16,
  parameter int SCALE   = 13926,
  parameter int SHIFT   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             hist_rden,
  output logic [7:0]       hist_rdaddr,
  input  logic [BIN_W-1:0] hist_q,
  output logic             hist_wren,
  output logic [7:0]       hist_wraddr,
  output logic             update,
  output logic [7:0]       update_address,
  output logic [7:0]       update_data,
  output logic             busy,
  output logic             done,
  output logic             overrun
);
  // update is a push-only strobe: the LUT accepts a write on every cycle update=1,
  // there is no ready; the address/data pair is valid only in that cycle.
  logic [1:0]       state_q, state_d;
  logic [7:0]       rd_cnt_q, rd_cnt_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_addr_q, rd_addr_d;
  logic [BIN_W-1:0] cdf_q, cdf_d;
  logic             cdf_valid_q, cdf_valid_d;
  logic [7:0]       cdf_addr_q, cdf_addr_d;
  logic [BIN_W:0]   cdf_sum;
  logic             start_accept;

  assign start_accept = start && (state_q == S_IDLE || state_q == S_FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      drain_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      cdf_q       <= '0;
      cdf_valid_q <= 1'b0;
      cdf_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      cdf_q       <= cdf_d;
      cdf_valid_q <= cdf_valid_d;
      cdf_addr_q  <= cdf_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          state_d  = S_READ;
          rd_cnt_d = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        rd_cnt_d = rd_cnt_q + 8'd1;
        if (rd_cnt_q == 8'(NBINS - 1)) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 2'd0;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (drain_cnt_q == 2'(PIPE_LAT - 1)) state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulate one cycle after the read; the sum carries an extra bit to detect saturation.
  always_comb begin
    rd_valid_d  = (state_q == S_READ);
    rd_addr_d   = rd_cnt_q;
    cdf_sum     = {1'b0, cdf_q} + {1'b0, hist_q};
    cdf_d       = cdf_q;
    if (start_accept)
      cdf_d = '0;
    else if (rd_valid_q)
      cdf_d = cdf_sum[BIN_W] ? {BIN_W{1'b1}} : cdf_sum[BIN_W-1:0];
    cdf_valid_d = rd_valid_q;
    cdf_addr_d  = rd_addr_q;
  end

  always_comb begin
    hist_rden   = (state_q == S_READ);
    hist_rdaddr = (state_q == S_READ) ? rd_cnt_q : 8'd0;
    busy        = (state_q == S_READ) || (state_q == S_DRAIN);
    done        = (state_q == S_FIN);
    overrun     = start && busy;
`ifdef HIST_CLEAR_EN
    hist_wren   = rd_valid_q;
    hist_wraddr = rd_valid_q ? rd_addr_q : 8'd0;
`else
    hist_wren   = 1'b0;
    hist_wraddr = 8'd0;
`endif
  end

  hist_lut_scale #(
    .BIN_W  (BIN_W),
    .SCALE_W(SCALE_W),
    .SCALE  (SCALE),
    .SHIFT  (SHIFT)
  ) u_scale (
    .clk      (clk),
    .rst      (rst),
    .in_valid (cdf_valid_q),
    .in_addr  (cdf_addr_q),
    .in_cdf   (cdf_q),
    .out_valid(update),
    .out_addr (update_address),
    .out_data (update_data)
  );
endmodule

// File: tb/tb_hist_lut_loader.sv
// Directed bench for hist_lut_loader: histogram RAM model, negedge stream monitor and
// immediate-assertion checks. Build with +define+HIST_CLEAR_EN to exercise bin clearing.
module tb_hist_lut_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        hist_rden;
  logic [7:0]  hist_rdaddr;
  logic [19:0] hist_q = '0;
  logic        hist_wren;
  logic [7:0]  hist_wraddr;
  logic        update;
  logic [7:0]  update_address;
  logic [7:0]  update_data;
  logic        busy;
  logic        done;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hist_lut_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .hist_rden(hist_rden), .hist_rdaddr(hist_rdaddr), .hist_q(hist_q),
    .hist_wren(hist_wren), .hist_wraddr(hist_wraddr),
    .update(update), .update_address(update_address), .update_data(update_data),
    .busy(busy), .done(done), .overrun(overrun)
  );

  // Histogram RAM model: registered read, clear-on-write, bulk fill on request.
  logic [19:0] hist_mem [256];
  logic        fill_req = 1'b0;
  int          fill_mode = 0;

  function automatic logic [19:0] fill_fn(input int mode, input int i);
    case (mode)
      0:       return 20'd1200;
      1:       return (i == 0) ? 20'd307200 : 20'd0;
      default: return 20'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 256; i++) hist_mem[i] <= fill_fn(fill_mode, i);
    end else if (hist_wren) begin
      hist_mem[hist_wraddr] <= '0;
    end
    if (hist_rden) hist_q <= hist_mem[hist_rdaddr];
  end

  // Stream monitor (sole writer of the recorded statistics)
  logic [7:0] lut [256];
  logic       clr_req = 1'b0;
  int upd_cnt, gap_err, first_upd, last_upd, done_cnt, done_cyc, busy_cnt;
  int ovr_cnt, ovr_cyc, wren_cnt, wren_gap, t_start;
  logic [7:0] exp_addr, exp_wr;

  always @(negedge clk) begin
    if (clr_req) begin
      upd_cnt = 0; gap_err = 0; first_upd = -1; last_upd = -1; done_cnt = 0;
      done_cyc = -1; busy_cnt = 0; ovr_cnt = 0; ovr_cyc = -1; wren_cnt = 0;
      wren_gap = 0; exp_addr = 8'd0; exp_wr = 8'd0;
      for (int i = 0; i < 256; i++) lut[i] = 8'd0;
    end else begin
      if (start && !busy) t_start = cyc;
      if (update) begin
        lut[update_address] = update_data;
        if (update_address !== exp_addr) gap_err++;
        exp_addr = exp_addr + 8'd1;
        if (upd_cnt == 0) first_upd = cyc;
        last_upd = cyc;
        upd_cnt++;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (overrun) begin ovr_cnt++; ovr_cyc = cyc; end
      if (hist_wren) begin
        if (hist_wraddr !== exp_wr) wren_gap++;
        exp_wr = exp_wr + 8'd1;
        wren_cnt++;
      end
    end
  end

  // Scoreboard helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lut_err(input int mode);
    longint cdf, p;
    int errs;
    logic [7:0] e;
    cdf = 0; errs = 0;
    for (int i = 0; i < 256; i++) begin
      cdf += longint'(fill_fn(mode, i));
      if (cdf > 1048575) cdf = 1048575;
      p = (cdf * 13926 + 64'd8388608) >>> 24;
      e = (p > 255) ? 8'd255 : 8'(p);
      if (lut[i] !== e) errs++;
    end
    return errs;
  endfunction

  // Driver tasks
  task automatic load_hist(input int mode);
    @(posedge clk); #1 fill_mode = mode; fill_req = 1'b1;
    @(posedge clk); #1 fill_req = 1'b0;
  endtask

  task automatic clear_mon();
    @(posedge clk); #1 clr_req = 1'b1;
    @(negedge clk); #1 clr_req = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_cycle(input int target);
    int k = 0;
    while (cyc != target && k < 2000) begin @(posedge clk); #1; k++; end
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done_cnt < n && k < 1000) begin @(posedge clk); k++; end
    chk("done_timeout", 32'(done_cnt >= n), 32'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic run_full(input string tag, input int mode);
    load_hist(mode);
    clear_mon();
    pulse_start();
    wait_done(1);
    chk({tag, "_upd_cnt"}, 32'(upd_cnt), 32'd256);
    chk({tag, "_gap"}, 32'(gap_err), 32'd0);
    chk({tag, "_lut_model"}, 32'(lut_err(mode)), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_rden", 32'(hist_rden), 32'd0);
    chk("rst_wren", 32'(hist_wren), 32'd0);
    chk("rst_data", 32'(update_data), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: uniform histogram, 1200 per bin
    run_full("uni", 0);
    chk("uni_lut0", 32'(lut[0]), 32'd1);
    chk("uni_lut127", 32'(lut[127]), 32'd127);
    chk("uni_lut255", 32'(lut[255]), 32'd255);
    chk("uni_first_upd", 32'(first_upd - t_start), 32'd4);
    chk("uni_last_upd", 32'(last_upd - t_start), 32'd259);
    chk("uni_done_at", 32'(done_cyc - t_start), 32'd260);
    chk("uni_done_cnt", 32'(done_cnt), 32'd1);
    chk("uni_busy_cyc", 32'(busy_cnt), 32'd259);
`ifndef HIST_CLEAR_EN
    chk("uni_no_wren", 32'(wren_cnt), 32'd0);
`endif

    // 2: all pixels in bin 0
    run_full("spike", 1);
    chk("spike_lut0", 32'(lut[0]), 32'd255);
    chk("spike_lut200", 32'(lut[200]), 32'd255);

    // 3: empty histogram
    run_full("zero", 2);
    chk("zero_lut255", 32'(lut[255]), 32'd0);
    chk("zero_busy_cyc", 32'(busy_cnt), 32'd259);

    // 4: start pulsed mid-sequence
    load_hist(0);
    clear_mon();
    pulse_start();
    wait_cycle(t_start + 100);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(1);
    chk("ovr_cnt", 32'(ovr_cnt), 32'd1);
    chk("ovr_at", 32'(ovr_cyc - t_start), 32'd100);
    chk("ovr_upd_cnt", 32'(upd_cnt), 32'd256);
    chk("ovr_lut_model", 32'(lut_err(0)), 32'd0);
    chk("ovr_done_cnt", 32'(done_cnt), 32'd1);
    chk("ovr_done_at", 32'(done_cyc - t_start), 32'd260);

    // 5: reset in the middle of a sequence
    load_hist(0);
    clear_mon();
    pulse_start();
    wait_cycle(t_start + 50);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_update", 32'(update), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (300) @(posedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    run_full("after_rst", 0);
    chk("after_rst_lut127", 32'(lut[127]), 32'd127);

    // start coinciding with done: back-to-back sequences
    load_hist(0);
    clear_mon();
    pulse_start();
    wait_cycle(t_start + 260);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(2);
    chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
    chk("b2b_upd_cnt", 32'(upd_cnt), 32'd512);
    chk("b2b_gap", 32'(gap_err), 32'd0);
    chk("b2b_overrun", 32'(ovr_cnt), 32'd0);
    chk("b2b_done_at", 32'(done_cyc - t_start), 32'd260);

`ifdef HIST_CLEAR_EN
    // 6: bins cleared as read; second pass sees an empty histogram
    run_full("clr1", 0);
    chk("clr_wren_cnt", 32'(wren_cnt), 32'd256);
    chk("clr_wren_gap", 32'(wren_gap), 32'd0);
    clear_mon();
    pulse_start();
    wait_done(1);
    chk("clr2_lut_model", 32'(lut_err(2)), 32'd0);
    chk("clr2_lut255", 32'(lut[255]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
